// File: rtl/parity_word_checker.sv
// Receive-side parity checker with a one-stage valid/ready output register,
// sticky/saturating error reporting and optional halt-on-error. Define
// ODD_PARITY_EN to treat in_par as odd parity instead of even.
module parity_word_checker #(
  parameter int W           = 4,
  parameter int CNT_W       = 8,
  parameter int DROP_BAD    = 1,
  parameter int HALT_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_bad,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic             halted,
  input  logic             clr
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             vld_q, vld_d;
  logic [W-1:0]     data_q, data_d;
  logic             bad_q, bad_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic par_calc, bad, acc, load, drain;

`ifdef ODD_PARITY_EN
  assign par_calc = ~^in_data;
`else
  assign par_calc = ^in_data;
`endif

  assign bad   = (par_calc != in_par);
  assign acc   = in_valid && in_ready;
  assign drain = vld_q && out_ready;
  // Dropped bad words never reach the register; a held word is left untouched.
  assign load  = acc && (!bad || (DROP_BAD == 0));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM: next state (clr takes priority over a concurrent error)
  always_comb begin
    state_d = state_q;
    if (clr)
      state_d = RUN;
    else if (state_q == RUN && acc && bad && (HALT_ON_ERR != 0))
      state_d = HALT;
  end

  // FSM: outputs
  always_comb begin
    halted   = (state_q == HALT);
    in_ready = !rst && (state_q == RUN) && (!vld_q || out_ready);
  end

  always_comb begin
    vld_d    = vld_q;
    data_d   = data_q;
    bad_d    = bad_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = in_data;
      bad_d  = bad;
    end else if (drain) begin
      vld_d  = 1'b0;
    end
    err_d    = acc && bad;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (acc && bad) begin
      sticky_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      data_q   <= '0;
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      data_q   <= data_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_data   = data_q;
  assign out_bad    = bad_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

endmodule

// File: doc/parity_word_checker.md
Name: parity_word_checker

Overview:
- Receive-side companion to the parity-checked adder: consumes a stream of W-bit result words, each with its predicted parity bit, and recomputes parity on the received data.
- Forwards good words through a one-stage registered valid/ready pipeline.
- Reports each mismatch and keeps a sticky flag and a saturating error count.
- Can freeze the stream on the first error until software clears it.

Parameters:
- W, 4, data word width in bits (>=1).
- CNT_W, 8, width of the error counter.
- DROP_BAD, 1, 1 = words failing parity are not forwarded; 0 = forwarded with out_bad=1.
- HALT_ON_ERR, 0, 1 = enter HALT after an error, 0 = keep running.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  checker can accept a word this cycle.
- in_data  input  W  received data word (adder z).
- in_par  input  1  predicted even parity of in_data (adder zp).
- out_valid  output  1  registered word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  W  forwarded data.
- out_bad  output  1  forwarded word failed parity (only meaningful when DROP_BAD=0).
- err  output  1  one-cycle pulse, registered, on each failing word accepted.
- err_sticky  output  1  set by any error, cleared only by clr or rst.
- err_cnt  output  CNT_W  saturating count of failing words.
- halted  output  1  FSM in HALT.
- clr  input  1  synchronous clear of err_sticky, err_cnt and HALT.

Behaviour:
- Reset (async, rst=1): all outputs 0, state RUN, output register empty; in_ready=0 while rst is high.
- Accept: a word is accepted when in_valid && in_ready at a rising edge.
- Parity check:
  - Without ODD_PARITY_EN: bad = (^in_data) != in_par.
  - With ODD_PARITY_EN: bad = (~^in_data) != in_par.
- Pipeline: single output register, latency 1 cycle from accept to out_valid.
  - in_ready = (state==RUN) && (!out_valid || out_ready); accept and drain can occur in the same cycle.
  - out_data, out_bad and out_valid hold stable while out_valid && !out_ready.
  - out_valid clears after a transfer if no new word is loaded.
- Bad word, DROP_BAD=1: the word is not loaded.
  - If the register drains the same cycle, out_valid goes 0.
  - Otherwise the held word stays untouched.
- Bad word, DROP_BAD=0: the word is loaded normally with out_bad=1.
- Error side effects (cycle after accepting a bad word):
  - err=1 for exactly one cycle.
  - err_sticky=1.
  - err_cnt increments, saturating at 2^CNT_W-1 (no wrap).
- Back-to-back bad words give consecutive err pulses and one count each.
- FSM:
  - RUN: normal operation. Goes to HALT when a bad word is accepted and HALT_ON_ERR=1.
  - HALT: in_ready=0, halted=1. The output register still drains to downstream. Returns to RUN on clr.
- clr:
  - Next edge: err_sticky=0, err_cnt=0, state RUN.
  - If a bad word is accepted in the same cycle as clr, clr wins for err_sticky and err_cnt (they read 0, not 1), but err still pulses.
  - clr does not touch the output register.
- rst mid-transfer: the pending word is discarded immediately and out_valid drops asynchronously.

Optional Feature:
- Macro ODD_PARITY_EN.
- Defined: in_par is interpreted as odd parity (the XOR of in_data and in_par must be 1).
- Undefined: even parity, matching the existing adder's zp convention.
- Port list is identical in both builds.

Test Plan:
- Good word: W=4, in_data=0011, in_par=0, out_ready=1 -> next cycle out_valid=1, out_data=0011, out_bad=0, err=0, err_cnt=0.
- Bad word dropped: DROP_BAD=1, in_data=0011, in_par=1 -> next cycle err=1, err_sticky=1, err_cnt=1, out_valid=0. A following good 0111/1 is forwarded with no error.
- Backpressure: out_ready=0 with one word held -> in_ready=0, out_data stable for 5 cycles. Raising out_ready with a new word present -> simultaneous drain and load, no word lost or duplicated.
- Saturation: CNT_W=2, six consecutive bad words -> err_cnt reads 1,2,3,3,3,3 and err pulses 6 times. clr -> err_cnt=0, err_sticky=0.
- Halt: HALT_ON_ERR=1, bad word 1000/0 -> halted=1, in_ready=0 while the held word still drains. clr -> RUN, and the next word 0001/1 is accepted.
- Async reset: assert rst mid-cycle with out_valid=1 -> out_valid, err_cnt and err_sticky go 0 without waiting for a clock edge. Repeat the good-word case under ODD_PARITY_EN with in_par=1 -> no error.
